// File: rtl/lampfpu_sqrt_arb.sv
// Round-robin arbiter sharing one lampFPU_sqrt unit; grant is Mealy in IDLE, doSqrt one cycle later.
// One operation in flight; rsp_* held until rsp_ready_i, and no grant is issued while a response waits.
module lampfpu_sqrt_arb #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 32,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*22-1:0] op_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  sqrt_doSqrt_o,
  output logic                  sqrt_invSqrt_o,
  output logic                  sqrt_signum_o,
  output logic [7:0]            sqrt_extExp_o,
  output logic [7:0]            sqrt_extMant_o,
  output logic                  sqrt_isInf_o,
  output logic                  sqrt_isZero_o,
  output logic                  sqrt_isSNAN_o,
  output logic                  sqrt_isQNAN_o,
  input  logic                  sqrt_valid_i,
  input  logic                  sqrt_s_res_i,
  input  logic [7:0]            sqrt_e_res_i,
  input  logic [11:0]           sqrt_f_res_i,
  input  logic                  sqrt_isToRound_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic                  rsp_s_o,
  output logic [7:0]            rsp_e_o,
  output logic [11:0]           rsp_f_o,
  output logic                  rsp_isToRound_o,
  output logic                  rsp_timeout_o
);

  localparam int OP_W  = 22;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic             rsp_s_q, rsp_s_d;
  logic [7:0]       rsp_e_q, rsp_e_d;
  logic [11:0]      rsp_f_q, rsp_f_d;
  logic             rsp_rnd_q, rsp_rnd_d;
  logic             rsp_to_q, rsp_to_d;

  logic             win_vld;
  logic [ID_W-1:0]  win_id;
  int               arb_idx;

  // Cyclic search starting one past the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    arb_idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_vld && req_i[arb_idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(arb_idx);
      end
    end
  end

  assign tmr_inc = tmr_q + TMR_W'(1);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    tmr_d     = tmr_q;
    rsp_s_d   = rsp_s_q;
    rsp_e_d   = rsp_e_q;
    rsp_f_d   = rsp_f_q;
    rsp_rnd_d = rsp_rnd_q;
    rsp_to_d  = rsp_to_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          op_d     = op_i[int'(win_id)*OP_W +: OP_W];
          id_d     = win_id;
          rr_ptr_d = win_id;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_inc;
        // A valid arriving on the limit cycle still wins over the watchdog.
        if (sqrt_valid_i) begin
          rsp_s_d   = sqrt_s_res_i;
          rsp_e_d   = sqrt_e_res_i;
          rsp_f_d   = sqrt_f_res_i;
          rsp_rnd_d = sqrt_isToRound_i;
          rsp_to_d  = 1'b0;
          state_d   = S_RESP;
        end else if (tmr_inc == TMR_W'(TIMEOUT_CYC)) begin
          rsp_s_d   = 1'b0;
          rsp_e_d   = '0;
          rsp_f_d   = '0;
          rsp_rnd_d = 1'b0;
          rsp_to_d  = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      op_q      <= '0;
      tmr_q     <= '0;
      rsp_s_q   <= 1'b0;
      rsp_e_q   <= '0;
      rsp_f_q   <= '0;
      rsp_rnd_q <= 1'b0;
      rsp_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      op_q      <= op_d;
      tmr_q     <= tmr_d;
      rsp_s_q   <= rsp_s_d;
      rsp_e_q   <= rsp_e_d;
      rsp_f_q   <= rsp_f_d;
      rsp_rnd_q <= rsp_rnd_d;
      rsp_to_q  <= rsp_to_d;
    end
  end

  // Grant is masked by rst so every output is quiet while reset is held.
  assign gnt_o = (state_q == S_IDLE && win_vld && !rst) ?
                 (NUM_REQ'(1) << win_id) : '0;

  assign sqrt_doSqrt_o  = (state_q == S_ISSUE);
  assign sqrt_invSqrt_o = op_q[21];
  assign sqrt_signum_o  = op_q[20];
  assign sqrt_extExp_o  = op_q[19:12];
  assign sqrt_extMant_o = op_q[11:4];
  assign sqrt_isInf_o   = op_q[3];
  assign sqrt_isZero_o  = op_q[2];
  assign sqrt_isSNAN_o  = op_q[1];
  assign sqrt_isQNAN_o  = op_q[0];

  assign rsp_valid_o     = (state_q == S_RESP);
  assign rsp_id_o        = id_q;
  assign rsp_s_o         = rsp_s_q;
  assign rsp_e_o         = rsp_e_q;
  assign rsp_f_o         = rsp_f_q;
  assign rsp_isToRound_o = rsp_rnd_q;
  assign rsp_timeout_o   = rsp_to_q;

endmodule

// File: tb/tb_lampfpu_sqrt_arb.sv
// Scoreboard bench for lampfpu_sqrt_arb with a latency-programmable sqrt stub.
module tb_lampfpu_sqrt_arb;

  localparam int NR   = 2;
  localparam int TO   = 32;
  localparam int ID_W = 1;

  localparam logic [21:0] OP_A = {1'b0, 1'b0, 8'h81, 8'h80, 4'b0000};
  localparam logic [21:0] OP_B = {1'b0, 1'b1, 8'h7E, 8'h9C, 4'b0000};
  localparam logic [21:0] OP_N = {1'b1, 1'b1, 8'hFF, 8'hC0, 4'b0010};

  logic            clk, rst;
  logic [NR-1:0]   req;
  logic [NR*22-1:0] op;
  logic [NR-1:0]   gnt_o;
  logic            sqrt_doSqrt_o, sqrt_invSqrt_o, sqrt_signum_o;
  logic [7:0]      sqrt_extExp_o, sqrt_extMant_o;
  logic            sqrt_isInf_o, sqrt_isZero_o, sqrt_isSNAN_o, sqrt_isQNAN_o;
  logic            sq_valid, sq_s, sq_rnd;
  logic [7:0]      sq_e;
  logic [11:0]     sq_f;
  logic            rsp_valid_o, rsp_ready;
  logic [ID_W-1:0] rsp_id_o;
  logic            rsp_s_o, rsp_isToRound_o, rsp_timeout_o;
  logic [7:0]      rsp_e_o;
  logic [11:0]     rsp_f_o;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  int   stub_cnt;
  int   stub_lat;
  logic stub_dead, stray;

  lampfpu_sqrt_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .op_i(op), .gnt_o(gnt_o),
    .sqrt_doSqrt_o(sqrt_doSqrt_o), .sqrt_invSqrt_o(sqrt_invSqrt_o),
    .sqrt_signum_o(sqrt_signum_o), .sqrt_extExp_o(sqrt_extExp_o),
    .sqrt_extMant_o(sqrt_extMant_o), .sqrt_isInf_o(sqrt_isInf_o),
    .sqrt_isZero_o(sqrt_isZero_o), .sqrt_isSNAN_o(sqrt_isSNAN_o),
    .sqrt_isQNAN_o(sqrt_isQNAN_o), .sqrt_valid_i(sq_valid),
    .sqrt_s_res_i(sq_s), .sqrt_e_res_i(sq_e), .sqrt_f_res_i(sq_f),
    .sqrt_isToRound_i(sq_rnd), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id_o), .rsp_s_o(rsp_s_o),
    .rsp_e_o(rsp_e_o), .rsp_f_o(rsp_f_o), .rsp_isToRound_o(rsp_isToRound_o),
    .rsp_timeout_o(rsp_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sqrt stub: valid pulses stub_lat cycles after the doSqrt cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) stub_cnt <= 0;
    else if (sqrt_doSqrt_o) stub_cnt <= stub_lat;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end
  assign sq_valid = ((stub_cnt == 1) && !stub_dead) || stray;

  function automatic logic [23:0] mk_rsp(input logic [ID_W-1:0] id, input logic s,
                                         input logic [7:0] e, input logic [11:0] f,
                                         input logic r, input logic t);
    return {id, s, e, f, r, t};
  endfunction

  function automatic logic [23:0] rsp_vec();
    return {rsp_id_o, rsp_s_o, rsp_e_o, rsp_f_o, rsp_isToRound_o, rsp_timeout_o};
  endfunction

  function automatic logic [21:0] op_vec();
    return {sqrt_invSqrt_o, sqrt_signum_o, sqrt_extExp_o, sqrt_extMant_o,
            sqrt_isInf_o, sqrt_isZero_o, sqrt_isSNAN_o, sqrt_isQNAN_o};
  endfunction

  function automatic logic [49:0] all_outs();
    return {gnt_o, sqrt_doSqrt_o, op_vec(), rsp_valid_o, rsp_vec()};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every handshake pops one expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid_o && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got %h expected none", rsp_vec());
      end else begin
        chk("rsp", 64'(rsp_vec()), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stub(input int lat, input logic s, input logic [7:0] e,
                          input logic [11:0] f, input logic r);
    stub_lat = lat; sq_s = s; sq_e = e; sq_f = f; sq_rnd = r;
  endtask

  // Entered at a drive point; returns at the settle point of the grant cycle.
  task automatic wait_gnt(input string nm, input logic [NR-1:0] expg);
    logic [NR-1:0] g;
    g = '0;
    for (int c = 0; c < 60; c++) begin
      #2;
      if (gnt_o != '0) begin
        g = gnt_o;
        break;
      end
      step();
    end
    chk(nm, 64'(g), 64'(expg));
  endtask

  task automatic drain(input string nm);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      step();
      c++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0d pending responses expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] snap;
    logic        gflag, sflag, oflag;
    rst = 1'b1; req = '0; op = '0; rsp_ready = 1'b1;
    stub_dead = 1'b0; stray = 1'b0;
    set_stub(10, 1'b0, 8'h80, 12'h5A3, 1'b1);
    #2;
    chk("reset_outs", 64'(all_outs()), 64'd0);
    step();
    rst = 1'b0;

    // 1: single request, sqrt(4.0)
    op[21:0] = OP_A;
    req = 2'b01;
    #2;
    chk("t1_gnt_same_cycle", 64'(gnt_o), 64'(2'b01));
    chk("t1_dosqrt_low_at_gnt", 64'(sqrt_doSqrt_o), 64'd0);
    exp_q.push_back(mk_rsp(1'b0, 1'b0, 8'h80, 12'h5A3, 1'b1, 1'b0));
    step();
    req = '0;
    #2;
    chk("t1_dosqrt_issue", 64'(sqrt_doSqrt_o), 64'd1);
    chk("t1_ops_issue", 64'(op_vec()), 64'(OP_A));
    step();
    #2;
    chk("t1_dosqrt_one_cycle", 64'(sqrt_doSqrt_o), 64'd0);
    drain("t1_drain");

    // 2: both requesting continuously, fresh pointer
    do_reset();
    set_stub(4, 1'b0, 8'h3C, 12'h123, 1'b0);
    op[21:0] = OP_A;
    op[43:22] = OP_B;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("t2_gnt_order", (k % 2 == 0) ? 2'b01 : 2'b10);
      exp_q.push_back(mk_rsp(ID_W'(k % 2), 1'b0, 8'h3C, 12'h123, 1'b0, 1'b0));
      step();
    end
    req = '0;
    drain("t2_drain");

    // 3: watchdog, stub never answers
    stub_dead = 1'b1;
    rsp_ready = 1'b0;
    req = 2'b01;
    wait_gnt("t3_gnt", 2'b01);
    exp_q.push_back(mk_rsp(1'b0, 1'b0, 8'h00, 12'h000, 1'b0, 1'b1));
    step();
    req = '0;
    #2;
    chk("t3_dosqrt", 64'(sqrt_doSqrt_o), 64'd1);
    repeat (TO) step();
    #2;
    chk("t3_not_before_limit", 64'(rsp_valid_o), 64'd0);
    step();
    #2;
    chk("t3_rsp_after_limit", 64'(rsp_valid_o), 64'd1);
    chk("t3_timeout_flag", 64'(rsp_timeout_o), 64'd1);
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    #2;
    chk("t3_stray_in_resp", 64'(rsp_vec()), 64'(mk_rsp(1'b0, 1'b0, 8'h00, 12'h000, 1'b0, 1'b1)));
    rsp_ready = 1'b1;
    drain("t3_drain");
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    #2;
    chk("t3_stray_in_idle", 64'({rsp_valid_o, sqrt_doSqrt_o}), 64'd0);
    stub_dead = 1'b0;

    // 4: consumer stalls 20 cycles while requester 1 waits
    set_stub(3, 1'b1, 8'h7F, 12'hABC, 1'b0);
    rsp_ready = 1'b0;
    req = 2'b01;
    wait_gnt("t4_gnt0", 2'b01);
    exp_q.push_back(mk_rsp(1'b0, 1'b1, 8'h7F, 12'hABC, 1'b0, 1'b0));
    step();
    req = '0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (rsp_valid_o) break;
      step();
    end
    snap = rsp_vec();
    chk("t4_rsp_fields", 64'(snap), 64'(mk_rsp(1'b0, 1'b1, 8'h7F, 12'hABC, 1'b0, 1'b0)));
    req = 2'b10;
    gflag = 1'b0;
    sflag = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      #2;
      if (gnt_o != '0) gflag = 1'b1;
      if (rsp_vec() != snap || !rsp_valid_o) sflag = 1'b1;
    end
    chk("t4_no_gnt_in_resp", 64'(gflag), 64'd0);
    chk("t4_rsp_stable", 64'(sflag), 64'd0);
    step();
    rsp_ready = 1'b1;
    #2;
    chk("t4_no_gnt_handshake", 64'(gnt_o), 64'd0);
    step();
    #2;
    chk("t4_gnt_after_idle", 64'(gnt_o), 64'(2'b10));
    chk("t4_valid_dropped", 64'(rsp_valid_o), 64'd0);
    exp_q.push_back(mk_rsp(1'b1, 1'b1, 8'h7F, 12'hABC, 1'b0, 1'b0));
    step();
    req = '0;
    drain("t4_drain");

    // 5: reset during WAIT
    set_stub(20, 1'b0, 8'h55, 12'h0F0, 1'b1);
    req = 2'b10;
    wait_gnt("t5_gnt1", 2'b10);
    step();
    req = '0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_rst_outs", 64'(all_outs()), 64'd0);
    step();
    step();
    rst = 1'b0;
    req = 2'b11;
    #2;
    chk("t5_prio_after_rst", 64'(gnt_o), 64'(2'b01));
    exp_q.push_back(mk_rsp(1'b0, 1'b0, 8'h55, 12'h0F0, 1'b1, 1'b0));
    step();
    req = '0;
    drain("t5_drain");

    // 6: special-case operand forwarded untouched
    set_stub(6, 1'b1, 8'hFF, 12'h800, 1'b0);
    op[43:22] = OP_N;
    req = 2'b10;
    wait_gnt("t6_gnt1", 2'b10);
    exp_q.push_back(mk_rsp(1'b1, 1'b1, 8'hFF, 12'h800, 1'b0, 1'b0));
    step();
    req = '0;
    op = '0;
    #2;
    chk("t6_ops_issue", 64'(op_vec()), 64'(OP_N));
    oflag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      #2;
      if (op_vec() != OP_N) oflag = 1'b1;
      if (rsp_valid_o) break;
    end
    chk("t6_ops_held", 64'(oflag), 64'd0);
    drain("t6_drain");

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
